// File: rtl/bp_common_pkg.sv
// Shared BedRock message types and helpers for the multi-accelerator sacc tile I/O dispatch.
package bp_common_pkg;

    localparam int sacc_max_channels_gp = 8;
    localparam int paddr_width_gp       = 40;
    localparam int cce_data_width_gp    = 64;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bp_bedrock_mem_type_e;

    typedef struct packed {
        bp_bedrock_mem_type_e        msg_type;
        logic [2:0]                  size;
        logic [paddr_width_gp-1:0]   addr;
    } bp_bedrock_cce_mem_hdr_s;

    typedef struct packed {
        bp_bedrock_cce_mem_hdr_s       header;
        logic [cce_data_width_gp-1:0]  data;
    } bp_bedrock_cce_mem_msg_s;

    // Width of an index into n things, never less than one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small flop-based FIFO with one write and one read port; pointers wrap modulo els_p.
module bsg_fifo_1r1w_small
    import bp_common_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] els_lp  = cnt_w_lp'(els_p);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, rptr_q;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                push, pop;

    assign ready_o = (cnt_q != els_lp);
    assign v_o     = (cnt_q != '0);
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wptr_q <= (wptr_q == last_lp) ? '0 : wptr_q + ptr_w_lp'(1);
            if (pop)  rptr_q <= (rptr_q == last_lp) ? '0 : rptr_q + ptr_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_sacc_io_dispatch.sv
// Fans one io_cce command stream out to num_sacc_p accelerators and returns responses in command order.
// Optional BP_SACC_DISPATCH_PERF_EN adds per-channel accepted-command counters on cmd_count_o.
module bp_sacc_io_dispatch
    import bp_common_pkg::*;
#(
    parameter int num_sacc_p        = 2,
    parameter int sel_lsb_p         = 20,
    parameter int max_outstanding_p = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  bp_bedrock_cce_mem_msg_s                   io_cmd_i,
    input  logic                                      io_cmd_v_i,
    output logic                                      io_cmd_ready_and_o,
    output bp_bedrock_cce_mem_msg_s                   io_resp_o,
    output logic                                      io_resp_v_o,
    input  logic                                      io_resp_yumi_i,
    output bp_bedrock_cce_mem_msg_s [num_sacc_p-1:0]  sacc_cmd_o,
    output logic [num_sacc_p-1:0]                     sacc_cmd_v_o,
    input  logic [num_sacc_p-1:0]                     sacc_cmd_ready_and_i,
    input  bp_bedrock_cce_mem_msg_s [num_sacc_p-1:0]  sacc_resp_i,
    input  logic [num_sacc_p-1:0]                     sacc_resp_v_i,
    output logic [num_sacc_p-1:0]                     sacc_resp_ready_and_o,
    output logic [num_sacc_p-1:0][31:0]               cmd_count_o,
    output logic                                      busy_o
);

    localparam int sel_width_lp = safe_clog2(num_sacc_p);
    localparam logic [sel_width_lp:0] num_lp = (sel_width_lp+1)'(num_sacc_p);

    logic [sel_width_lp-1:0]  sel, head;
    logic [num_sacc_p-1:0]    sel_hit, head_hit;
    logic                     legal, full, empty, fifo_ready, fifo_v;
    logic                     accel_ready, push, pop, err_accept;
    logic                     err_pending_q;
    bp_bedrock_cce_mem_hdr_s  err_hdr_q;

    assign sel         = io_cmd_i.header.addr[sel_lsb_p +: sel_width_lp];
    assign legal       = ({1'b0, sel} < num_lp);
    assign full        = ~fifo_ready;
    assign empty       = ~fifo_v;
    assign accel_ready = |(sel_hit & sacc_cmd_ready_and_i);

    // Illegal commands wait for a drained tracker so the error reply cannot overtake older responses.
    assign io_cmd_ready_and_o = ~reset_i & ~err_pending_q & (legal ? (accel_ready & ~full) : empty);
    assign push       = io_cmd_v_i & io_cmd_ready_and_o & legal;
    assign err_accept = io_cmd_v_i & io_cmd_ready_and_o & ~legal;
    assign pop        = io_resp_yumi_i & ~empty & ~err_pending_q;
    assign busy_o     = ~empty | err_pending_q;

    bsg_fifo_1r1w_small #(
        .width_p (sel_width_lp),
        .els_p   (max_outstanding_p)
    ) tracker (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (push),
        .ready_o (fifo_ready),
        .data_i  (sel),
        .v_o     (fifo_v),
        .data_o  (head),
        .yumi_i  (pop)
    );

    for (genvar c = 0; c < num_sacc_p; c++) begin : g_ch
        assign sel_hit[c]               = legal & (sel == sel_width_lp'(c));
        assign head_hit[c]              = (head == sel_width_lp'(c));
        assign sacc_cmd_o[c]            = io_cmd_i;
        assign sacc_cmd_v_o[c]          = ~reset_i & io_cmd_v_i & sel_hit[c] & ~full & ~err_pending_q;
        assign sacc_resp_ready_and_o[c] = ~empty & head_hit[c] & io_resp_yumi_i;
    end

    always_comb begin
        io_resp_o   = '0;
        io_resp_v_o = 1'b0;
        if (err_pending_q) begin
            io_resp_o.header = err_hdr_q;
            io_resp_v_o      = 1'b1;
        end else if (~empty) begin
            io_resp_v_o = |(head_hit & sacc_resp_v_i);
            for (int i = 0; i < num_sacc_p; i++)
                if (head_hit[i]) io_resp_o = sacc_resp_i[i];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_pending_q <= 1'b0;
            err_hdr_q     <= '0;
        end else if (err_accept) begin
            err_pending_q <= 1'b1;
            err_hdr_q     <= io_cmd_i.header;
        end else if (err_pending_q & io_resp_yumi_i) begin
            err_pending_q <= 1'b0;
        end
    end

`ifdef BP_SACC_DISPATCH_PERF_EN
    logic [num_sacc_p-1:0][31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < num_sacc_p; i++)
            if (sacc_cmd_v_o[i] & sacc_cmd_ready_and_i[i]) cnt_d[i] = cnt_q[i] + 32'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cmd_count_o = cnt_q;
`else
    assign cmd_count_o = '0;
`endif

endmodule
